// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - F3_*        : RV32I load/store funct3 width/sign encodings
//   - mem_state_t : access sequencer states
//   - XLEN_DEFAULT: default datapath/address width
package riscv_mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for loads and stores.
//   addr       in  : byte address (only [1:0] steers lanes, [1:0] checked for alignment)
//   funct3     in  : RV32I width/sign encoding
//   is_store   in  : 1 = store, 0 = load
//   store_data in  : rs2 value to be written
//   load_word  in  : raw word returned by memory
//   wstrb      out : byte strobes (0 for loads)
//   wdata      out : store data replicated across all lanes
//   load_data  out : selected and extended load result
//   illegal    out : unsupported funct3 for the direction, or misaligned address
module lsu_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] addr,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Shift the addressed lane down to bit 0 so a single slice picks byte or half.
  assign shifted  = load_word >> {addr[1:0], 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = shifted[15:0];

  always_comb begin
    wstrb     = 4'b0000;
    wdata     = '0;
    load_data = '0;
    illegal   = 1'b0;
    case (funct3)
      F3_B: begin
        wstrb     = is_store ? (4'b0001 << addr[1:0]) : 4'b0000;
        wdata     = {(XLEN/8){store_data[7:0]}};
        load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        illegal   = addr[0];
        wstrb     = is_store ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0000;
        wdata     = {(XLEN/16){store_data[15:0]}};
        load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      end
      F3_W: begin
        illegal   = (addr[1:0] != 2'b00);
        wstrb     = is_store ? 4'b1111 : 4'b0000;
        wdata     = store_data;
        load_data = load_word;
      end
      F3_BU: begin
        illegal   = is_store;
        load_data = {{(XLEN-8){1'b0}}, byte_sel};
      end
      F3_HU: begin
        illegal   = is_store | addr[0];
        load_data = {{(XLEN-16){1'b0}}, half_sel};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: consumes EX/MEM fields, performs one load/store over a
// valid/ready request + response-valid handshake, stalls earlier stages while
// the access is outstanding and registers the MEM/WB fields.
//   clk, reset (sync, active-low)
//   in_*            : EX/MEM pipeline register fields
//   mem_req_*       : request channel (valid/ready), word-aligned address
//   mem_resp_*      : read data / write acknowledge
//   out_stall       : hold EX/MEM and earlier stages
//   out_wb_data, out_rd, out_write_enable, out_fault : MEM/WB register
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MAX_WAIT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_mem_write,
  input  logic            in_mem_read,
  input  logic            in_mem_to_reg,
  input  logic            in_write_enable,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_stall,
  output logic [XLEN-1:0] out_wb_data,
  output logic [4:0]      out_rd,
  output logic            out_write_enable,
  output logic            out_fault
);

  localparam int             CW   = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(MAX_WAIT - 1);

  mem_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rd_reg;
  logic [3:0]      wstrb_reg;
  logic            store_reg, we_reg, m2r_reg, timeout_reg;

  logic            is_mem, idle, illegal;
  logic [XLEN-1:0] al_addr, al_wdata, al_load;
  logic [2:0]      al_funct3;
  logic            al_store;
  logic [3:0]      al_wstrb;

  assign is_mem = in_mem_read | in_mem_write;
  assign idle   = (state_reg == IDLE);

  // One aligner serves both ends of the access: in IDLE it looks at the live
  // EX/MEM fields (legality, strobes, store data); afterwards it sees the
  // latched copies so DONE can format the captured read word.
  assign al_addr   = idle ? in_alu_out   : addr_reg;
  assign al_funct3 = idle ? in_funct3    : funct3_reg;
  assign al_store  = idle ? in_mem_write : store_reg;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr      (al_addr),
    .funct3    (al_funct3),
    .is_store  (al_store),
    .store_data(in_mem_data),
    .load_word (rdata_reg),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .load_data (al_load),
    .illegal   (illegal)
  );

  assign mem_req_valid = (state_reg == ISSUE);
  assign mem_req_we    = store_reg;
  assign mem_req_addr  = {addr_reg[XLEN-1:2], 2'b00};
  assign mem_req_wdata = wdata_reg;
  assign mem_req_wstrb = wstrb_reg;
  assign out_stall     = (idle & is_mem & ~illegal) | (state_reg == ISSUE) | (state_reg == WAIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (is_mem && !illegal) state_next = ISSUE;
      ISSUE:   if (mem_req_ready) state_next = WAIT;
      WAIT:    if (mem_resp_valid || cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      rdata_reg        <= '0;
      funct3_reg       <= '0;
      rd_reg           <= '0;
      wstrb_reg        <= '0;
      store_reg        <= 1'b0;
      we_reg           <= 1'b0;
      m2r_reg          <= 1'b0;
      timeout_reg      <= 1'b0;
      out_wb_data      <= '0;
      out_rd           <= '0;
      out_write_enable <= 1'b0;
      out_fault        <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          timeout_reg <= 1'b0;
          if (!is_mem || illegal) begin
            // Single-cycle result: plain ALU op or a rejected access.
            out_wb_data      <= in_alu_out;
            out_rd           <= in_rd;
            out_write_enable <= is_mem ? 1'b0 : in_write_enable;
            out_fault        <= is_mem;
          end else begin
            // Latch everything now; EX/MEM is not trusted to hold while stalled.
            addr_reg         <= in_alu_out;
            funct3_reg       <= in_funct3;
            rd_reg           <= in_rd;
            we_reg           <= in_write_enable;
            m2r_reg          <= in_mem_to_reg;
            store_reg        <= in_mem_write;
            wstrb_reg        <= al_wstrb;
            wdata_reg        <= al_wdata;
            // Bubble into MEM/WB while the access is outstanding.
            out_wb_data      <= '0;
            out_rd           <= '0;
            out_write_enable <= 1'b0;
            out_fault        <= 1'b0;
          end
        end
        ISSUE: cnt_reg <= '0;
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (mem_resp_valid) begin
            if (!store_reg) rdata_reg <= mem_resp_rdata;
          end else if (cnt_reg == LAST) begin
            timeout_reg <= 1'b1;
          end
        end
        DONE: begin
          cnt_reg          <= '0;
          timeout_reg      <= 1'b0;
          out_wb_data      <= m2r_reg ? al_load : addr_reg;
          out_rd           <= rd_reg;
          out_write_enable <= timeout_reg ? 1'b0 : we_reg;
          out_fault        <= timeout_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int MAXW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_alu_out = '0, in_mem_data = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_mem_write = 0, in_mem_read = 0, in_mem_to_reg = 0, in_write_enable = 0;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_resp_rdata = '0;
  logic        out_stall, out_write_enable, out_fault;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;

  int n_chk = 0;
  int n_err = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .in_alu_out(in_alu_out), .in_mem_data(in_mem_data), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
    .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_stall(out_stall), .out_wb_data(out_wb_data), .out_rd(out_rd),
    .out_write_enable(out_write_enable), .out_fault(out_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (spec rules, plain arithmetic) --------
  function automatic bit m_legal(bit st, logic [2:0] f3, logic [31:0] a);
    bit f3_ok;
    if (st) f3_ok = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else    f3_ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (!f3_ok) return 0;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 0;
    if (f3 == 2 && (a % 4 != 0)) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(a % 4) * 8)) & 32'hFF;
    h = (w >> ((a % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wstrb(bit st, logic [2:0] f3, logic [31:0] a);
    if (!st) return 0;
    case (f3)
      3'd0:    return 32'(1) << (a % 4);
      3'd1:    return (a % 4 >= 2) ? 32'd12 : 32'd3;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Entered and left at posedge+1. Drives one EX/MEM instruction and plays memory.
  task automatic run_op(input string name, input bit mr, input bit mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input bit we, input bit m2r, input int rdy_dly, input int rsp_dly,
                        input bit no_resp, input logic [31:0] word);
    bit          is_mem, st, legal, done;
    int          cyc;
    logic [31:0] e_addr, e_strb, e_wd, e_wb;
    is_mem = mr | mw;
    st     = mw;
    legal  = m_legal(st, f3, a);
    e_addr = a & 32'hFFFF_FFFC;
    e_strb = m_wstrb(st, f3, a);
    e_wd   = m_wdata(f3, d);
    in_alu_out = a; in_mem_data = d; in_funct3 = f3; in_rd = rd;
    in_mem_read = mr; in_mem_write = mw; in_mem_to_reg = m2r; in_write_enable = we;
    #1;
    check({name, ".stall_idle"}, 32'(out_stall), 32'(is_mem && legal));
    n_txn++;
    if (!is_mem || !legal) begin
      @(posedge clk); #1;
      check({name, ".req_valid"}, 32'(mem_req_valid), 0);
      check({name, ".fault"}, 32'(out_fault), 32'(is_mem));
      check({name, ".we"}, 32'(out_write_enable), is_mem ? 0 : 32'(we));
      check({name, ".rd"}, 32'(out_rd), 32'(rd));
      if (!is_mem) check({name, ".wb"}, out_wb_data, a);
      $display("txn %0d %s nonmem=%0d fault=%0d wb=%h rd=%0d we=%0d", n_txn, name,
               !is_mem, out_fault, out_wb_data, out_rd, out_write_enable);
      return;
    end
    @(posedge clk); #1;
    // Scramble the EX/MEM fields: the stage must work from its own latches.
    in_alu_out = $urandom; in_mem_data = $urandom; in_funct3 = 3'($urandom);
    in_rd = 5'($urandom); in_mem_read = 0; in_mem_write = 0; in_write_enable = 1'($urandom);
    #1;
    for (int k = 0; k <= rdy_dly; k++) begin
      check({name, ".req_valid"}, 32'(mem_req_valid), 1);
      check({name, ".req_addr"}, mem_req_addr, e_addr);
      check({name, ".req_we"}, 32'(mem_req_we), 32'(st));
      check({name, ".req_wstrb"}, 32'(mem_req_wstrb), e_strb);
      if (st) check({name, ".req_wdata"}, mem_req_wdata, e_wd);
      check({name, ".stall_issue"}, 32'(out_stall), 1);
      if (k == rdy_dly) mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
    end
    check({name, ".req_drop"}, 32'(mem_req_valid), 0);
    done = 0; cyc = 0;
    for (int i = 0; i < MAXW + 4; i++) begin
      check({name, ".stall_wait"}, 32'(out_stall), 1);
      mem_resp_valid = (!no_resp && i == rsp_dly);
      mem_resp_rdata = word;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      if (!out_stall) begin done = 1; cyc = i + 1; break; end
    end
    check({name, ".done_reached"}, 32'(done), 1);
    check({name, ".wait_cycles"}, cyc, no_resp ? MAXW : rsp_dly + 1);
    @(posedge clk); #1;
    check({name, ".fault"}, 32'(out_fault), 32'(no_resp));
    check({name, ".we"}, 32'(out_write_enable), no_resp ? 0 : 32'(we));
    check({name, ".rd"}, 32'(out_rd), 32'(rd));
    if (!no_resp) begin
      e_wb = m2r ? m_load(f3, a, word) : a;
      check({name, ".wb"}, out_wb_data, e_wb);
    end
    $display("txn %0d %s st=%0d addr=%h fault=%0d wb=%h rd=%0d we=%0d wait=%0d", n_txn, name,
             st, a, out_fault, out_wb_data, out_rd, out_write_enable, cyc);
  endtask

  initial begin
    bit          mr, mw, m2r, nr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;

    repeat (3) @(posedge clk);
    #1;
    check("reset.wb", out_wb_data, 0);
    check("reset.we", 32'(out_write_enable), 0);
    check("reset.fault", 32'(out_fault), 0);
    check("reset.req_valid", 32'(mem_req_valid), 0);
    check("reset.stall", 32'(out_stall), 0);
    reset = 1;
    @(posedge clk); #1;

    run_op("alu",    0, 0, 3'd0, 32'h1234, 0, 5'd5, 1, 0, 0, 0, 0, 0);
    run_op("lb",     1, 0, 3'd0, 32'h103, 0, 5'd7, 1, 1, 0, 3, 0, 32'h80FF_FF00);
    run_op("sh",     0, 1, 3'd1, 32'h202, 32'hABCD_1234, 5'd0, 0, 0, 2, 1, 0, 0);
    run_op("lw_mis", 1, 0, 3'd2, 32'h301, 0, 5'd9, 1, 1, 0, 0, 0, 0);
    run_op("lw_to",  1, 0, 3'd2, 32'h400, 0, 5'd3, 1, 1, 0, 0, 1, 32'h5555_AAAA);
    run_op("lw_last",1, 0, 3'd2, 32'h404, 0, 5'd4, 1, 1, 0, MAXW - 1, 0, 32'hCAFE_F00D);
    run_op("rw_st",  1, 1, 3'd0, 32'h503, 32'h77, 5'd1, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of WAIT, then a stray response.
    in_alu_out = 32'h600; in_funct3 = 3'd2; in_mem_read = 1; in_rd = 5'd8;
    in_write_enable = 1; in_mem_to_reg = 1;
    mem_req_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    in_mem_read = 0; in_alu_out = 0; in_rd = 0; in_write_enable = 0; in_mem_to_reg = 0;
    check("rst_mid.stall_wait", 32'(out_stall), 1);
    reset = 0;
    @(posedge clk); #1;
    check("rst_mid.req_valid", 32'(mem_req_valid), 0);
    check("rst_mid.req_addr", mem_req_addr, 0);
    check("rst_mid.wb", out_wb_data, 0);
    check("rst_mid.stall", 32'(out_stall), 0);
    reset = 1;
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    check("rst_mid.late_stall", 32'(out_stall), 0);
    check("rst_mid.late_we", 32'(out_write_enable), 0);
    check("rst_mid.late_fault", 32'(out_fault), 0);
    $display("txn reset-mid-wait stall=%0d valid=%0d", out_stall, mem_req_valid);
    run_op("post_rst", 1, 0, 3'd4, 32'h701, 0, 5'd2, 1, 1, 0, 0, 0, 32'h0000_9900);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      mr = 0; mw = 0; m2r = 0;
      a  = $urandom;
      if (kind == 1) begin
        mr = 1; m2r = 1'($urandom);
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else if (kind == 2) begin
        mw = 1; mr = 1'($urandom);
        f3 = 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom);
      end
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      nr = ($urandom_range(0, 15) == 0);
      run_op("rnd", mr, mw, f3, a, $urandom, 5'($urandom), 1'($urandom), m2r,
             $urandom_range(0, 3), $urandom_range(0, 5), nr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
